// File: rtl/min_metric_select.sv
// ---------------------------------------------------------------------------
// min_metric_select
//
// Purpose:
//   Finds the best (minimum path-metric) trellis state after the ACS array
//   completes a block. The result is the start node for the traceback stage.
//   The scan is time-multiplexed: LANES metrics are compared per clock. This
//   keeps the comparator count fixed no matter how many states there are.
//   On a tie, the lower state index always wins.
//
// Configuration:
//   MIN_PM_OUT_EN - when defined, adds port o_min_pm. It carries the minimum
//                   metric, registered alongside o_sel_node. When undefined,
//                   the metric path ends at the internal running-best
//                   register. o_sel_node timing is the same in both builds.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   i_start    in   one-cycle scan request, ignored while o_busy=1
//   i_pm       in   flattened metrics, state s at [s*PM_W +: PM_W]
//   o_sel_node out  index of the minimum-metric state, held until next result
//   o_valid    out  one-cycle pulse when o_sel_node updates
//   o_min_pm   out  minimum metric value (MIN_PM_OUT_EN only)
//   o_busy     out  high while a scan is in progress
// ---------------------------------------------------------------------------
module min_metric_select #(
    parameter int NUM_ST = 256,
    parameter int ST_W   = 8,
    parameter int PM_W   = 16,
    parameter int LANES  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [NUM_ST*PM_W-1:0] i_pm,
    output logic [ST_W-1:0]        o_sel_node,
    output logic                   o_valid,
`ifdef MIN_PM_OUT_EN
    output logic [PM_W-1:0]        o_min_pm,
`endif
    output logic                   o_busy
);

    localparam int NUM_CHUNK = NUM_ST / LANES;
    localparam int CNT_W     = $clog2(NUM_CHUNK);
    localparam int LANE_W    = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [PM_W-1:0]  r_snap [NUM_ST];
    logic [CNT_W-1:0] r_chunk;
    logic [ST_W-1:0]  r_bestIdx;
    logic [PM_W-1:0]  r_bestPm;
    logic [ST_W-1:0]  r_selNode;
`ifdef MIN_PM_OUT_EN
    logic [PM_W-1:0]  r_minPm;
`endif

    logic             w_accept;
    logic [PM_W-1:0]  w_chunkPm;
    logic [ST_W-1:0]  w_chunkIdx;
    logic             w_chunkWins;
    logic [PM_W-1:0]  w_newPm;
    logic [ST_W-1:0]  w_newIdx;

    // A request is taken in IDLE and also in DONE. Accepting it in DONE
    // lets back-to-back scans run with only one idle cycle between results.
    assign w_accept = i_start && (r_state != S_SCAN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. The scan ends on the last chunk, so the counter
    // never wraps into an extra pass.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_nextState = S_SCAN;
            S_SCAN:  if (r_chunk == LAST_CHUNK) w_nextState = S_DONE;
            S_DONE:  w_nextState = w_accept ? S_SCAN : S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Snapshot bank. The scan reads only this copy, so i_pm may change
    // freely once a request has been accepted. It holds data only, so it
    // has no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int s = 0; s < NUM_ST; s++) begin
                r_snap[s] <= i_pm[s*PM_W +: PM_W];
            end
        end
    end

    // Reduction tree over the current chunk. Level 0 holds the lanes in
    // ascending state order. Each node keeps its left (lower-index) child
    // unless the right child is strictly smaller, so ties resolve to the
    // lowest index.
    for (genvar lv = 0; lv <= LANE_W; lv++) begin : g_lvl
        localparam int N = LANES >> lv;
        logic [PM_W-1:0] w_pm  [N];
        logic [ST_W-1:0] w_idx [N];
        for (genvar j = 0; j < N; j++) begin : g_node
            if (lv == 0) begin : g_leaf
                assign w_idx[j] = {r_chunk, LANE_W'(j)};
                assign w_pm[j]  = r_snap[{r_chunk, LANE_W'(j)}];
            end else begin : g_cmp
                logic w_takeRight;
                assign w_takeRight = g_lvl[lv-1].w_pm[2*j+1] < g_lvl[lv-1].w_pm[2*j];
                assign w_pm[j]  = w_takeRight ? g_lvl[lv-1].w_pm[2*j+1]  : g_lvl[lv-1].w_pm[2*j];
                assign w_idx[j] = w_takeRight ? g_lvl[lv-1].w_idx[2*j+1] : g_lvl[lv-1].w_idx[2*j];
            end
        end
    end

    assign w_chunkPm  = g_lvl[LANE_W].w_pm[0];
    assign w_chunkIdx = g_lvl[LANE_W].w_idx[0];

    // The running best always comes from earlier chunks, so it has a lower
    // index. The chunk winner must therefore be strictly smaller to replace it.
    assign w_chunkWins = w_chunkPm < r_bestPm;
    assign w_newPm     = w_chunkWins ? w_chunkPm  : r_bestPm;
    assign w_newIdx    = w_chunkWins ? w_chunkIdx : r_bestIdx;

    // Scan datapath. A new request seeds the running best with the worst
    // possible metric. Each scan cycle folds in one chunk, and the final
    // chunk's result goes straight to the output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chunk   <= '0;
            r_bestIdx <= '0;
            r_bestPm  <= '1;
            r_selNode <= '0;
`ifdef MIN_PM_OUT_EN
            r_minPm   <= '0;
`endif
        end else if (w_accept) begin
            r_chunk   <= '0;
            r_bestIdx <= '0;
            r_bestPm  <= '1;
        end else if (r_state == S_SCAN) begin
            r_chunk   <= r_chunk + 1'b1;
            r_bestIdx <= w_newIdx;
            r_bestPm  <= w_newPm;
            if (r_chunk == LAST_CHUNK) begin
                r_selNode <= w_newIdx;
`ifdef MIN_PM_OUT_EN
                r_minPm   <= w_newPm;
`endif
            end
        end
    end

    assign o_sel_node = r_selNode;
    assign o_valid    = (r_state == S_DONE);
    assign o_busy     = (r_state == S_SCAN);
`ifdef MIN_PM_OUT_EN
    assign o_min_pm   = r_minPm;
`endif

endmodule

// File: tb/tb_min_metric_select.sv
// ---------------------------------------------------------------------------
// tb_min_metric_select
//
// Directed testbench for min_metric_select with default parameters
// (256 states, 8 lanes, 32-cycle scan). Each expected value is worked out by
// hand from the stimulus pattern. o_min_pm is checked only when
// MIN_PM_OUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_min_metric_select;

    localparam int NUM_ST = 256;
    localparam int ST_W   = 8;
    localparam int PM_W   = 16;
    localparam int LANES  = 8;
    localparam int PMV_W  = NUM_ST * PM_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic [PMV_W-1:0] i_pm;
    logic [ST_W-1:0]  o_sel_node;
    logic             o_valid;
    logic             o_busy;
`ifdef MIN_PM_OUT_EN
    logic [PM_W-1:0]  o_min_pm;
`endif

    int vectors     = 0;
    int miscompares = 0;

    min_metric_select #(
        .NUM_ST (NUM_ST),
        .ST_W   (ST_W),
        .PM_W   (PM_W),
        .LANES  (LANES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_pm       (i_pm),
        .o_sel_node (o_sel_node),
        .o_valid    (o_valid),
`ifdef MIN_PM_OUT_EN
        .o_min_pm   (o_min_pm),
`endif
        .o_busy     (o_busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Advance one cycle, then settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive the metric vector and an optional start pulse for one edge.
    task automatic applyStimulus(input logic [PMV_W-1:0] pm, input logic start);
        i_pm    = pm;
        i_start = start;
        tick();
        i_start = 1'b0;
    endtask

    // Count edges until o_valid is seen. cycles stays -1 on timeout.
    task automatic waitValid(input int budget, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = -1;
        for (int c = 1; c <= budget; c++) begin
            if (!found) begin
                tick();
                if (o_valid === 1'b1) begin
                    found  = 1'b1;
                    cycles = c;
                end
            end
        end
    endtask

    function automatic logic [PMV_W-1:0] fillPm(input logic [PM_W-1:0] v);
        logic [PMV_W-1:0] r;
        for (int s = 0; s < NUM_ST; s++) r[s*PM_W +: PM_W] = v;
        return r;
    endfunction

    function automatic logic [PMV_W-1:0] setPm(input logic [PMV_W-1:0] base, input int s,
                                               input logic [PM_W-1:0] v);
        logic [PMV_W-1:0] r;
        r = base;
        r[s*PM_W +: PM_W] = v;
        return r;
    endfunction

    // One full scan: start, check latency, result, and a single-cycle pulse.
    task automatic runScan(input string tag, input logic [PMV_W-1:0] pm,
                           input int expIdx, input int expPm);
        int cycles;
        applyStimulus(pm, 1'b1);
        checkOutput({tag, "_busy"}, 32'(o_busy), 1);
        waitValid(40, cycles);
        checkOutput({tag, "_latency"}, cycles, 32);
        checkOutput({tag, "_sel"}, 32'(o_sel_node), expIdx);
        checkOutput({tag, "_busyDone"}, 32'(o_busy), 0);
`ifdef MIN_PM_OUT_EN
        checkOutput({tag, "_minpm"}, 32'(o_min_pm), expPm);
`else
        if (expPm < 0) $display("[TB] note: negative metric expectation for %s", tag);
`endif
        tick();
        checkOutput({tag, "_validDrop"}, 32'(o_valid), 0);
    endtask

    logic [PMV_W-1:0] pmA;
    logic [PMV_W-1:0] pmB;
    int               cyc;
    int               cyc2;

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        i_pm    = '0;
        repeat (3) tick();
        checkOutput("reset_valid", 32'(o_valid), 0);
        checkOutput("reset_busy", 32'(o_busy), 0);
        checkOutput("reset_sel", 32'(o_sel_node), 0);
`ifdef MIN_PM_OUT_EN
        checkOutput("reset_minpm", 32'(o_min_pm), 0);
`endif
        rst = 1'b0;
        tick();

        // Ramp pm[s] = s + 10: state 0 is the minimum.
        for (int s = 0; s < NUM_ST; s++) pmA[s*PM_W +: PM_W] = PM_W'(s + 10);
        runScan("ramp", pmA, 0, 10);

        // Single small metric deep inside the table.
        runScan("single200", setPm(fillPm(16'h8000), 200, 16'h0003), 200, 3);

        // Tie across chunks, then a tie inside one chunk.
        runScan("tie5_250", setPm(setPm(fillPm(16'hFFFF), 5, 16'd1), 250, 16'd1), 5, 1);
        runScan("tie17_18", setPm(setPm(fillPm(16'hFFFF), 17, 16'd1), 18, 16'd1), 17, 1);

        // Minimum sits in the very last lane of the last chunk.
        runScan("last255", setPm(fillPm(16'hFFFF), 255, 16'hFFFE), 255, 16'hFFFE);

        // Everything equal to the seed metric: index 0 must hold.
        runScan("allMax", fillPm(16'hFFFF), 0, 16'hFFFF);

        // Second start and new metrics mid-scan must be ignored.
        pmA = setPm(fillPm(16'h4000), 100, 16'd2);
        applyStimulus(pmA, 1'b1);
        repeat (9) tick();
        applyStimulus(setPm(fillPm(16'h0000), 3, 16'h0000), 1'b1);
        checkOutput("ignore_busy", 32'(o_busy), 1);
        waitValid(40, cyc);
        checkOutput("ignore_latency", cyc + 10, 32);
        checkOutput("ignore_sel", 32'(o_sel_node), 100);
        tick();
        checkOutput("ignore_validDrop", 32'(o_valid), 0);

        // Reset in the middle of a scan aborts it with no pulse.
        applyStimulus(setPm(fillPm(16'hFFFF), 40, 16'd1), 1'b1);
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", 32'(o_busy), 0);
        checkOutput("abort_sel", 32'(o_sel_node), 0);
        checkOutput("abort_valid", 32'(o_valid), 0);
        waitValid(40, cyc);
        checkOutput("abort_noValid", cyc, -1);

        // Fresh scan, then a start on the DONE cycle.
        pmA = setPm(fillPm(16'hFFFF), 77, 16'd1);
        pmB = setPm(fillPm(16'hFFFF), 150, 16'd1);
        applyStimulus(pmA, 1'b1);
        waitValid(40, cyc);
        checkOutput("fresh_latency", cyc, 32);
        checkOutput("fresh_sel", 32'(o_sel_node), 77);
        applyStimulus(pmB, 1'b1);
        checkOutput("b2b_validDrop", 32'(o_valid), 0);
        checkOutput("b2b_busy", 32'(o_busy), 1);
        waitValid(40, cyc2);
        checkOutput("b2b_spacing", cyc2 + 1, 33);
        checkOutput("b2b_sel", 32'(o_sel_node), 150);
        tick();
        checkOutput("b2b_validDrop2", 32'(o_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
